mem_stage_banked: RTL and testbench

Parametrised successor to the pipeline memory stage: executes the load/store carried in `alu_signals` against a variable-latency, big-endian 16-bit data bus. Adds a data-bank address prefix, a ready handshake with a pipeline stall, byte enables, split handling of odd-address word accesses, byte-load sign extension, and a bus timeout. It sits between the ALU stage and writeback; non-memory instructions pass through in one cycle, as before.

---
 rtl/mem_stage_banked_pkg.sv | 40 ++++
 rtl/mem_lane_mux.sv | 44 ++++
 rtl/mem_stage_banked.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage_banked.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_banked_pkg.sv
// Shared types and constants for the banked pipeline memory stage.
package mem_stage_banked_pkg;

    // Instruction bundle handed from the ALU stage to writeback.
    // mem_read/mem_write: [0] = access enable, [1] = word (else byte).
    // data_out carries store data into the stage and load results out of it.
    typedef struct packed {
        logic [3:0]  rd;
        logic        reg_write;
        logic [1:0]  mem_read;
        logic [1:0]  mem_write;
        logic        mem_sext;
        logic [7:0]  mem_bank;
        logic [15:0] mem_addr;
        logic [15:0] data_out;
    } alu_signals;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2
    } mem_state_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_WORD = 2'b11;

    // Widen a loaded byte to 16 bits, sign- or zero-extended.
    function automatic logic [15:0] ext_byte(input logic [7:0] b, input logic sext);
        logic [15:0] r;
        if (sext) begin
            r = {{8{b[7]}}, b};
        end else begin
            r = {8'h00, b};
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Byte-lane steering for the big-endian 16-bit data bus.
// Request side: byte enables and write-data replication.
// Response side: lane select and extension of loaded bytes.
module mem_lane_mux
    import mem_stage_banked_pkg::*;
(
    input  logic        req_word,
    input  logic        req_odd,
    input  logic [15:0] wr_datum,
    output logic [1:0]  be,
    output logic [15:0] wr_data,
    input  logic        rsp_word,
    input  logic        rsp_odd,
    input  logic        rsp_sext,
    input  logic [15:0] bus_data,
    output logic [15:0] rd_data
);

    // Request lanes: word uses both, a byte goes on both lanes with one enabled.
    always_comb begin
        be      = BE_NONE;
        wr_data = 16'h0000;
        if (req_word) begin
            be      = BE_WORD;
            wr_data = wr_datum;
        end else begin
            be      = req_odd ? BE_LO : BE_HI;
            wr_data = {wr_datum[7:0], wr_datum[7:0]};
        end
    end

    // Response lanes: word passes through, a byte is taken from its lane.
    always_comb begin
        rd_data = 16'h0000;
        if (rsp_word) begin
            rd_data = bus_data;
        end else if (rsp_odd) begin
            rd_data = ext_byte(bus_data[7:0], rsp_sext);
        end else begin
            rd_data = ext_byte(bus_data[15:8], rsp_sext);
        end
    end

endmodule

// File: rtl/mem_stage_banked.sv
// Pipeline memory stage: runs one load/store per instruction against a
// variable-latency banked bus, splitting odd-address word accesses into
// two byte cycles, with a wait timeout. Non-memory ops pass in one cycle.
module mem_stage_banked
    import mem_stage_banked_pkg::*;
#(
    parameter int ADDR_W         = 24,
    parameter int BANK_W         = 8,
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT        = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  alu_signals        ctrl_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_be_o,
    output logic [15:0]       mem_data_o,
    input  logic [15:0]       mem_data_i,
    input  logic              mem_ready_i,
    output alu_signals        ctrl_o,
    output logic              valid_o,
    output logic              fault_o
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0]   TO_VAL   = (CNT_W + 1)'(TIMEOUT);
    localparam logic             TO_EN    = (TIMEOUT != 0);
    localparam logic             SPLIT_EN = (MISALIGN_SPLIT != 0);

    mem_state_e        state_r, state_next;
    logic [CNT_W-1:0]  wait_cnt_r, cnt_next;
    logic [CNT_W:0]    cnt_inc;
    alu_signals        cap_r, cap_next;
    logic [7:0]        lo_byte_r, lo_next;
    logic [ADDR_W-1:0] addr_next;
    logic              re_next, we_next, valid_next, fault_next;
    logic [1:0]        be_next;
    logic [15:0]       wd_next;
    alu_signals        ctrl_next;

    logic              in_wr, in_rd, in_word, in_mem;
    logic              cap_rd, cap_word, cap_split;
    logic              req_word, req_odd;
    logic [15:0]       req_datum, req_wdata, rsp_data;
    logic [1:0]        req_be;

    // Decode of the incoming instruction and of the captured one; writes beat reads.
    always_comb begin
        in_wr     = ctrl_i.mem_write[0];
        in_rd     = ctrl_i.mem_read[0] & ~ctrl_i.mem_write[0];
        in_word   = in_wr ? ctrl_i.mem_write[1] : ctrl_i.mem_read[1];
        in_mem    = in_wr | in_rd;
        cap_rd    = cap_r.mem_read[0] & ~cap_r.mem_write[0];
        cap_word  = cap_r.mem_write[0] ? cap_r.mem_write[1] : cap_r.mem_read[1];
        cap_split = cap_word & cap_r.mem_addr[0];
        cnt_inc   = {1'b0, wait_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    end

    // Source of the next request: the new instruction in IDLE, else the
    // low byte of a split word (second half, even lane).
    always_comb begin
        req_word  = 1'b0;
        req_odd   = 1'b0;
        req_datum = 16'h0000;
        if (state_r == IDLE) begin
            req_word  = in_word & ~ctrl_i.mem_addr[0];
            req_odd   = ctrl_i.mem_addr[0];
            req_datum = (in_word & ctrl_i.mem_addr[0]) ? {8'h00, ctrl_i.data_out[15:8]}
                                                       : ctrl_i.data_out;
        end else begin
            req_word  = 1'b0;
            req_odd   = 1'b0;
            req_datum = {8'h00, cap_r.data_out[7:0]};
        end
    end

    mem_lane_mux u_lane (
        .req_word (req_word),
        .req_odd  (req_odd),
        .wr_datum (req_datum),
        .be       (req_be),
        .wr_data  (req_wdata),
        .rsp_word (cap_word & ~cap_r.mem_addr[0]),
        .rsp_odd  (mem_be_o == BE_LO),
        .rsp_sext (cap_r.mem_sext),
        .bus_data (mem_data_i),
        .rd_data  (rsp_data)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_next = state_r;
        cnt_next   = wait_cnt_r;
        cap_next   = cap_r;
        lo_next    = lo_byte_r;
        addr_next  = mem_addr_o;
        re_next    = mem_re_o;
        we_next    = mem_we_o;
        be_next    = mem_be_o;
        wd_next    = mem_data_o;
        ctrl_next  = ctrl_o;
        valid_next = 1'b0;
        fault_next = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    if (!in_mem) begin
                        ctrl_next  = ctrl_i;
                        valid_next = 1'b1;
                    end else if (in_word && ctrl_i.mem_addr[0] && !SPLIT_EN) begin
                        ctrl_next  = ctrl_i;
                        valid_next = 1'b1;
                        fault_next = 1'b1;
                    end else begin
                        cap_next   = ctrl_i;
                        addr_next  = {ctrl_i.mem_bank[BANK_W-1:0], ctrl_i.mem_addr};
                        re_next    = in_rd;
                        we_next    = in_wr;
                        be_next    = req_be;
                        wd_next    = req_wdata;
                        cnt_next   = {CNT_W{1'b0}};
                        state_next = ACC1;
                    end
                end else begin
                    valid_next = 1'b0;
                end
            end
            ACC1, ACC2: begin
                if (mem_ready_i) begin
                    if ((state_r == ACC1) && cap_split) begin
                        // First half of a split word arrives on the odd lane.
                        lo_next    = mem_data_i[7:0];
                        addr_next  = {mem_addr_o[ADDR_W-1:16], cap_r.mem_addr + 16'h0001};
                        be_next    = req_be;
                        wd_next    = req_wdata;
                        cnt_next   = {CNT_W{1'b0}};
                        state_next = ACC2;
                    end else begin
                        ctrl_next = cap_r;
                        if (cap_rd) begin
                            ctrl_next.data_out = (state_r == ACC2) ? {lo_byte_r, mem_data_i[15:8]}
                                                                   : rsp_data;
                        end else begin
                            ctrl_next.data_out = cap_r.data_out;
                        end
                        valid_next = 1'b1;
                        re_next    = 1'b0;
                        we_next    = 1'b0;
                        be_next    = BE_NONE;
                        state_next = IDLE;
                    end
                end else if (TO_EN && (cnt_inc == TO_VAL)) begin
                    ctrl_next = cap_r;
                    if (cap_rd) begin
                        ctrl_next.data_out = 16'hFFFF;
                    end else begin
                        ctrl_next.data_out = cap_r.data_out;
                    end
                    valid_next = 1'b1;
                    fault_next = 1'b1;
                    re_next    = 1'b0;
                    we_next    = 1'b0;
                    be_next    = BE_NONE;
                    cnt_next   = {CNT_W{1'b0}};
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_next = IDLE;
                re_next    = 1'b0;
                we_next    = 1'b0;
                be_next    = BE_NONE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
            cap_r      <= '0;
            lo_byte_r  <= 8'h00;
            busy_o     <= 1'b0;
            mem_addr_o <= {ADDR_W{1'b0}};
            mem_re_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= BE_NONE;
            mem_data_o <= 16'h0000;
            ctrl_o     <= '0;
            valid_o    <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            state_r    <= state_next;
            wait_cnt_r <= cnt_next;
            cap_r      <= cap_next;
            lo_byte_r  <= lo_next;
            busy_o     <= (state_next != IDLE);
            mem_addr_o <= addr_next;
            mem_re_o   <= re_next;
            mem_we_o   <= we_next;
            mem_be_o   <= be_next;
            mem_data_o <= wd_next;
            ctrl_o     <= ctrl_next;
            valid_o    <= valid_next;
            fault_o    <= fault_next;
        end
    end

endmodule

// File: tb/tb_mem_stage_banked.sv
// Directed bench for mem_stage_banked: one instance with split access and the
// default timeout, one with faulting misalign and a short timeout.
module tb_mem_stage_banked;
    import mem_stage_banked_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_a, busy_a, re_a, we_a, rdy_a, valid_a, fault_a;
    logic [23:0] addr_a;
    logic [1:0]  be_a;
    logic [15:0] wdo_a, rdi_a;
    alu_signals  ctrl_a, ctrl_o_a;

    logic        en_b, busy_b, re_b, we_b, rdy_b, valid_b, fault_b;
    logic [23:0] addr_b;
    logic [1:0]  be_b;
    logic [15:0] wdo_b, rdi_b;
    alu_signals  ctrl_b, ctrl_o_b;

    int checks = 0;
    int errors = 0;

    mem_stage_banked #(.ADDR_W(24), .BANK_W(8), .MISALIGN_SPLIT(1), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .ctrl_i(ctrl_a), .busy_o(busy_a),
        .mem_addr_o(addr_a), .mem_re_o(re_a), .mem_we_o(we_a), .mem_be_o(be_a),
        .mem_data_o(wdo_a), .mem_data_i(rdi_a), .mem_ready_i(rdy_a),
        .ctrl_o(ctrl_o_a), .valid_o(valid_a), .fault_o(fault_a)
    );

    mem_stage_banked #(.ADDR_W(24), .BANK_W(8), .MISALIGN_SPLIT(0), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .ctrl_i(ctrl_b), .busy_o(busy_b),
        .mem_addr_o(addr_b), .mem_re_o(re_b), .mem_we_o(we_b), .mem_be_o(be_b),
        .mem_data_o(wdo_b), .mem_data_i(rdi_b), .mem_ready_i(rdy_b),
        .ctrl_o(ctrl_o_b), .valid_o(valid_b), .fault_o(fault_b)
    );

    function automatic alu_signals mk(input logic [3:0] rd, input logic [1:0] mr,
                                      input logic [1:0] mw, input logic sx,
                                      input logic [7:0] bank, input logic [15:0] addr,
                                      input logic [15:0] data);
        alu_signals c;
        c.rd = rd; c.reg_write = 1'b1; c.mem_read = mr; c.mem_write = mw;
        c.mem_sext = sx; c.mem_bank = bank; c.mem_addr = addr; c.data_out = data;
        return c;
    endfunction

    task automatic test_reset();
        alu_signals z = '0;
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        rdi_a = 16'h0000; rdi_b = 16'h0000; ctrl_a = '0; ctrl_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, re_a, we_a, valid_a, fault_a, be_a} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0", {busy_a, re_a, we_a, valid_a, fault_a, be_a});
        end
        checks++;
        if ({addr_a, wdo_a} !== 40'h0) begin
            errors++; $display("FAIL reset_bus: got %h/%h expected 0", addr_a, wdo_a);
        end
        checks++;
        if (ctrl_o_a !== z) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_o_a);
        end
        checks++;
        if ({busy_b, valid_b, fault_b} !== 3'b0) begin
            errors++; $display("FAIL reset_b: got %b expected 0", {busy_b, valid_b, fault_b});
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        alu_signals c = mk(4'h3, 2'b00, 2'b00, 1'b0, 8'hAA, 16'h1234, 16'h5678);
        ctrl_a = c; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({valid_a, busy_a, re_a} !== 3'b100 || ctrl_o_a !== c) begin
            errors++; $display("FAIL passthrough: got v/b/r=%b ctrl=%h expected 100 ctrl=%h", {valid_a, busy_a, re_a}, ctrl_o_a, c);
        end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || ctrl_o_a !== c) begin
            errors++; $display("FAIL passthrough_hold: got v=%b ctrl=%h expected 0 ctrl=%h", valid_a, ctrl_o_a, c);
        end
    endtask

    task automatic test_idle_ready();
        rdy_a = 1'b1; rdi_a = 16'hDEAD;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if ({busy_a, re_a, we_a, valid_a} !== 4'b0) begin
            errors++; $display("FAIL idle_ready: got %b expected 0000", {busy_a, re_a, we_a, valid_a});
        end
    endtask

    task automatic test_byte_read();
        ctrl_a = mk(4'h1, 2'b01, 2'b00, 1'b1, 8'h12, 16'h0041, 16'h0000); en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({busy_a, re_a, we_a, valid_a, be_a, addr_a} !== {4'b1100, 2'b01, 24'h120041}) begin
            errors++; $display("FAIL byte_read_req: got b/r/w/v=%b be=%b addr=%h expected 1100 01 120041", {busy_a, re_a, we_a, valid_a}, be_a, addr_a);
        end
        rdy_a = 1'b1; rdi_a = 16'h3C80;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if ({valid_a, busy_a, re_a, be_a} !== 5'b10000 || ctrl_o_a.data_out !== 16'hFF80 || ctrl_o_a.rd !== 4'h1) begin
            errors++; $display("FAIL byte_read_sext: got v/b/r/be=%b data=%h expected 10000 FF80", {valid_a, busy_a, re_a, be_a}, ctrl_o_a.data_out);
        end
        // back-to-back: even byte, zero-extended
        ctrl_a = mk(4'h2, 2'b01, 2'b00, 1'b0, 8'h12, 16'h0040, 16'h0000); en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({busy_a, be_a, addr_a} !== {1'b1, 2'b10, 24'h120040}) begin
            errors++; $display("FAIL byte_read_even_req: got b=%b be=%b addr=%h expected 1 10 120040", busy_a, be_a, addr_a);
        end
        rdy_a = 1'b1; rdi_a = 16'h8011;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if (valid_a !== 1'b1 || ctrl_o_a.data_out !== 16'h0080) begin
            errors++; $display("FAIL byte_read_zext: got v=%b data=%h expected 1 0080", valid_a, ctrl_o_a.data_out);
        end
    endtask

    task automatic test_word_write();
        alu_signals c = mk(4'h0, 2'b00, 2'b11, 1'b0, 8'h05, 16'h0200, 16'hBEEF);
        ctrl_a = c; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy_a, we_a, re_a, valid_a, be_a, wdo_a, addr_a} !== {4'b1100, 2'b11, 16'hBEEF, 24'h050200}) begin
                errors++; $display("FAIL word_write_cyc%0d: got b/w/r/v=%b be=%b data=%h addr=%h expected 1100 11 BEEF 050200", i, {busy_a, we_a, re_a, valid_a}, be_a, wdo_a, addr_a);
            end
            rdy_a = (i == 3);
            @(negedge clk);
        end
        rdy_a = 1'b0;
        checks++;
        if ({valid_a, busy_a, we_a, fault_a, be_a} !== 6'b100000 || ctrl_o_a !== c) begin
            errors++; $display("FAIL word_write_done: got v/b/w/f/be=%b ctrl=%h expected 100000 ctrl=%h", {valid_a, busy_a, we_a, fault_a, be_a}, ctrl_o_a, c);
        end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++; $display("FAIL word_write_pulse: got v=%b expected 0", valid_a);
        end
    endtask

    task automatic test_byte_write();
        ctrl_a = mk(4'h0, 2'b01, 2'b01, 1'b0, 8'h00, 16'h0007, 16'h005A); en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({we_a, re_a, be_a, wdo_a} !== {2'b10, 2'b01, 16'h5A5A}) begin
            errors++; $display("FAIL byte_write_req: got w/r=%b be=%b data=%h expected 10 01 5A5A", {we_a, re_a}, be_a, wdo_a);
        end
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if ({valid_a, we_a, ctrl_o_a.data_out} !== {2'b10, 16'h005A}) begin
            errors++; $display("FAIL byte_write_done: got v/w=%b data=%h expected 10 005A", {valid_a, we_a}, ctrl_o_a.data_out);
        end
    endtask

    task automatic test_split_read();
        ctrl_a = mk(4'h7, 2'b11, 2'b00, 1'b0, 8'h33, 16'hFFFF, 16'h0000); en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({re_a, be_a, addr_a} !== {1'b1, 2'b01, 24'h33FFFF}) begin
            errors++; $display("FAIL split_read_acc1: got r=%b be=%b addr=%h expected 1 01 33FFFF", re_a, be_a, addr_a);
        end
        rdy_a = 1'b1; rdi_a = 16'h12AB;
        @(negedge clk);
        checks++;
        if ({busy_a, re_a, valid_a, be_a, addr_a} !== {3'b110, 2'b10, 24'h330000}) begin
            errors++; $display("FAIL split_read_acc2: got b/r/v=%b be=%b addr=%h expected 110 10 330000", {busy_a, re_a, valid_a}, be_a, addr_a);
        end
        rdi_a = 16'hCD34;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if ({valid_a, busy_a, ctrl_o_a.data_out} !== {2'b10, 16'hABCD}) begin
            errors++; $display("FAIL split_read_data: got v/b=%b data=%h expected 10 ABCD", {valid_a, busy_a}, ctrl_o_a.data_out);
        end
    endtask

    task automatic test_split_write();
        alu_signals c = mk(4'h0, 2'b00, 2'b11, 1'b0, 8'h44, 16'h0011, 16'h1234);
        ctrl_a = c; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if ({we_a, be_a, wdo_a, addr_a} !== {1'b1, 2'b01, 16'h1212, 24'h440011}) begin
            errors++; $display("FAIL split_write_acc1: got w=%b be=%b data=%h addr=%h expected 1 01 1212 440011", we_a, be_a, wdo_a, addr_a);
        end
        rdy_a = 1'b1;
        @(negedge clk);
        checks++;
        if ({we_a, be_a, wdo_a, addr_a} !== {1'b1, 2'b10, 16'h3434, 24'h440012}) begin
            errors++; $display("FAIL split_write_acc2: got w=%b be=%b data=%h addr=%h expected 1 10 3434 440012", we_a, be_a, wdo_a, addr_a);
        end
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if (valid_a !== 1'b1 || ctrl_o_a !== c) begin
            errors++; $display("FAIL split_write_done: got v=%b ctrl=%h expected 1 ctrl=%h", valid_a, ctrl_o_a, c);
        end
    endtask

    task automatic test_reset_mid();
        alu_signals z = '0;
        alu_signals c2 = mk(4'hE, 2'b00, 2'b00, 1'b0, 8'h01, 16'h0002, 16'h0BAD);
        ctrl_a = mk(4'h4, 2'b11, 2'b00, 1'b0, 8'h01, 16'h0101, 16'h0000); en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0; rdy_a = 1'b1; rdi_a = 16'h0000;
        @(negedge clk);
        rdy_a = 1'b0;
        checks++;
        if ({busy_a, be_a} !== 3'b110) begin
            errors++; $display("FAIL reset_mid_in_acc2: got b=%b be=%b expected 1 10", busy_a, be_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy_a, re_a, we_a, valid_a, fault_a, be_a} !== 7'b0 || {addr_a, wdo_a} !== 40'h0 || ctrl_o_a !== z) begin
            errors++; $display("FAIL reset_mid: got flags=%b addr=%h data=%h ctrl=%h expected all 0", {busy_a, re_a, we_a, valid_a, fault_a, be_a}, addr_a, wdo_a, ctrl_o_a);
        end
        ctrl_a = c2; en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if (valid_a !== 1'b1 || busy_a !== 1'b0 || ctrl_o_a !== c2) begin
            errors++; $display("FAIL reset_mid_pass: got v=%b b=%b ctrl=%h expected 1 0 ctrl=%h", valid_a, busy_a, ctrl_o_a, c2);
        end
    endtask

    task automatic test_misalign_fault();
        alu_signals c = mk(4'h9, 2'b11, 2'b00, 1'b1, 8'h0F, 16'h0101, 16'h4321);
        ctrl_b = c; en_b = 1'b1;
        @(negedge clk);
        en_b = 1'b0;
        checks++;
        if ({re_b, we_b, busy_b, valid_b, fault_b} !== 5'b00011 || ctrl_o_b !== c) begin
            errors++; $display("FAIL misalign_fault: got r/w/b/v/f=%b ctrl=%h expected 00011 ctrl=%h", {re_b, we_b, busy_b, valid_b, fault_b}, ctrl_o_b, c);
        end
        @(negedge clk);
        checks++;
        if ({re_b, busy_b, valid_b, fault_b} !== 4'b0000) begin
            errors++; $display("FAIL misalign_after: got r/b/v/f=%b expected 0000", {re_b, busy_b, valid_b, fault_b});
        end
    endtask

    task automatic test_timeout();
        alu_signals c = mk(4'h5, 2'b01, 2'b00, 1'b0, 8'h20, 16'h0010, 16'h1111);
        alu_signals e = c;
        e.data_out = 16'hFFFF;
        ctrl_b = c; en_b = 1'b1; rdy_b = 1'b0;
        @(negedge clk);
        en_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy_b, re_b, valid_b} !== 3'b110) begin
                errors++; $display("FAIL timeout_wait%0d: got b/r/v=%b expected 110", i, {busy_b, re_b, valid_b});
            end
            @(negedge clk);
        end
        checks++;
        if ({valid_b, fault_b, busy_b, re_b} !== 4'b1100 || ctrl_o_b !== e) begin
            errors++; $display("FAIL timeout_abort: got v/f/b/r=%b ctrl=%h expected 1100 ctrl=%h", {valid_b, fault_b, busy_b, re_b}, ctrl_o_b, e);
        end
        @(negedge clk);
        checks++;
        if ({valid_b, fault_b} !== 2'b00) begin
            errors++; $display("FAIL timeout_pulse: got v/f=%b expected 00", {valid_b, fault_b});
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_idle_ready();
        test_byte_read();
        test_word_write();
        test_byte_write();
        test_split_read();
        test_split_write();
        test_reset_mid();
        test_misalign_fault();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
